// File: rtl/dmem_access_unit.sv
// dmem_access_unit: the MEM-stage responder for the EX/MEM pipeline register.
// Each aligned load or store from EX/MEM becomes one req/gnt/rvalid transaction
// on the data-memory bus. The pipeline is stalled until that transaction
// completes or times out. Requests that set both read and write, or that use an
// unaligned address, are rejected with a one-cycle error pulse. They never
// reach the bus.
module dmem_access_unit #(
  parameter int TIMEOUT = 255,  // max cycles waiting for gnt or rvalid
  parameter int CNT_W   = 8     // timeout counter width; must hold TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_mem_mem_read,
  input  logic        ex_mem_mem_write,
  input  logic [31:0] ex_mem_alu_o,
  input  logic [31:0] ex_mem_rs2_for_mem,
  output logic        mem_stall,
  output logic [31:0] mem_rdata,
  output logic        mem_rdata_valid,
  output logic        mem_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    DONE   = 2'd3
  } state_t;

  // The counter value seen in the last allowed waiting cycle. If it is reached
  // with no gnt or rvalid, the transaction is aborted.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             rdata_valid_q, rdata_valid_d;
  logic             err_q, err_d;

  // A request is legal when exactly one of read/write is set and the address
  // is word aligned. Both set, or an unaligned access, is an error.
  logic req_any;
  logic req_ok;
  logic req_bad;

  assign req_any = ex_mem_mem_read | ex_mem_mem_write;
  assign req_ok  = (ex_mem_mem_read ^ ex_mem_mem_write) && (ex_mem_alu_o[1:0] == 2'b00);
  assign req_bad = req_any && !req_ok;

  // Next-state, datapath-update and combinational-output logic for the access FSM.
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path can leave a signal unassigned. An unassigned path infers a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    err_d         = 1'b0;
    mem_stall     = 1'b0;
    dmem_req      = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req_ok) begin
          // Latch the access now so the bus sees stable values. EX/MEM may
          // still change after the stall releases.
          we_d      = ex_mem_mem_write;
          addr_d    = ex_mem_alu_o;
          wdata_d   = ex_mem_rs2_for_mem;
          state_d   = REQ;
          // The pipeline must freeze in this same cycle. Otherwise EX/MEM
          // would advance past the access that was just captured.
          mem_stall = !rst;
        end else if (req_bad) begin
          err_d = 1'b1;
        end
      end

      REQ: begin
        dmem_req  = 1'b1;
        mem_stall = 1'b1;
        if (dmem_gnt) begin
          cnt_d   = '0;
          state_d = we_q ? DONE : WAIT_R;
        end else if (cnt_q == TO_LAST) begin
          // No grant in time: abort. A load still completes, with zero data,
          // so that writeback is not left waiting.
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = DONE;
          if (!we_q) begin
            rdata_d       = '0;
            rdata_valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      WAIT_R: begin
        mem_stall = 1'b1;
        if (dmem_rvalid) begin
          cnt_d         = '0;
          rdata_d       = dmem_rdata;
          rdata_valid_d = 1'b1;
          state_d       = DONE;
        end else if (cnt_q == TO_LAST) begin
          cnt_d         = '0;
          err_d         = 1'b1;
          rdata_d       = '0;
          rdata_valid_d = 1'b1;
          state_d       = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        // The stall is released here, so the pipeline advances at the end of
        // this cycle. EX/MEM still shows the finished instruction, so it is
        // not sampled. That prevents issuing the access a second time.
        cnt_d   = '0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter and output registers. A synchronous reset returns
  // everything to zero.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments. Every register
    // then updates from values taken before the clock edge.
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      err_q         <= err_d;
    end
  end

  assign dmem_we         = we_q;
  assign dmem_addr       = addr_q;
  assign dmem_wdata      = wdata_q;
  assign mem_rdata       = rdata_q;
  assign mem_rdata_valid = rdata_valid_q;
  assign mem_err         = err_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: a self-checking bench for dmem_access_unit.
// Each transaction's stall length, bus request length, error and load
// pulses, and returned data are predicted from the transaction's parameters:
// request type, grant delay and read-data delay.
module tb_dmem_access_unit;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_mem_mem_read;
  logic        ex_mem_mem_write;
  logic [31:0] ex_mem_alu_o;
  logic [31:0] ex_mem_rs2_for_mem;
  logic        mem_stall;
  logic [31:0] mem_rdata;
  logic        mem_rdata_valid;
  logic        mem_err;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  int          n_vec  = 0;
  int          n_miss = 0;
  logic [31:0] last_rdata = '0;

  dmem_access_unit #(.TIMEOUT(T), .CNT_W(8)) dut (
    .clk                (clk),
    .rst                (rst),
    .ex_mem_mem_read    (ex_mem_mem_read),
    .ex_mem_mem_write   (ex_mem_mem_write),
    .ex_mem_alu_o       (ex_mem_alu_o),
    .ex_mem_rs2_for_mem (ex_mem_rs2_for_mem),
    .mem_stall          (mem_stall),
    .mem_rdata          (mem_rdata),
    .mem_rdata_valid    (mem_rdata_valid),
    .mem_err            (mem_err),
    .dmem_req           (dmem_req),
    .dmem_we            (dmem_we),
    .dmem_addr          (dmem_addr),
    .dmem_wdata         (dmem_wdata),
    .dmem_gnt           (dmem_gnt),
    .dmem_rvalid        (dmem_rvalid),
    .dmem_rdata         (dmem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One EX/MEM access, entered and left 1 time unit after a rising edge.
  // g: number of request cycles without a grant before gnt (g >= T: never granted).
  // r: cycles from gnt to rvalid (>= 1). spur: also pulse rvalid in the gnt cycle.
  task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wd, input int g, input int r,
                         input logic [31:0] rdat, input bit spur);
    int          stall_n = 0, req_n = 0, err_n = 0, val_n = 0;
    logic [31:0] val_data = '0;
    bit          bus_bad = 1'b0;
    int          req_seen = 0, since_gnt = -1, cyc = 0, tail = 0;
    bit          ended = 1'b0;
    bit          ok, good_rvalid;
    int          e_stall, e_req, e_err, e_val;
    logic [31:0] e_data;

    // Expected results, derived from the request type and the bus delays.
    ok = (rd ^ wr) && (addr[1:0] == 2'b00);
    e_data = last_rdata;
    if (!(rd | wr)) begin
      e_stall = 0; e_req = 0; e_err = 0; e_val = 0;
    end else if (!ok) begin
      e_stall = 0; e_req = 0; e_err = 1; e_val = 0;
    end else if (g >= T) begin
      e_stall = T + 1; e_req = T; e_err = 1; e_val = rd ? 1 : 0;
      if (rd) e_data = '0;
    end else if (wr) begin
      e_stall = g + 2; e_req = g + 1; e_err = 0; e_val = 0;
    end else if (r <= T) begin
      e_stall = g + 2 + r; e_req = g + 1; e_err = 0; e_val = 1; e_data = rdat;
    end else begin
      e_stall = g + 2 + T; e_req = g + 1; e_err = 1; e_val = 1; e_data = '0;
    end

    ex_mem_mem_read    = rd;
    ex_mem_mem_write   = wr;
    ex_mem_alu_o       = addr;
    ex_mem_rs2_for_mem = wd;
    while (tail < 3 && cyc < 60) begin
      dmem_gnt    = dmem_req && (req_seen == g);
      good_rvalid = (since_gnt > 0) && (since_gnt == r);
      dmem_rvalid = good_rvalid || (spur && dmem_gnt);
      dmem_rdata  = good_rvalid ? rdat : ~rdat;
      #3;
      if (mem_stall) stall_n++;
      if (dmem_req) begin
        req_n++;
        if (dmem_addr !== addr || dmem_we !== wr || (wr && dmem_wdata !== wd)) bus_bad = 1'b1;
      end
      if (mem_err) err_n++;
      if (mem_rdata_valid) begin
        val_n++;
        val_data = mem_rdata;
      end
      if (rd && dmem_gnt) since_gnt = 1;
      else if (good_rvalid) since_gnt = -1;
      else if (since_gnt > 0) since_gnt++;
      if (dmem_req && !dmem_gnt) req_seen++;
      if (ended) tail++;
      else if (!mem_stall) ended = 1'b1;
      cyc++;
      @(posedge clk); #1;
      if (ended) begin
        ex_mem_mem_read  = 1'b0;
        ex_mem_mem_write = 1'b0;
      end
    end
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;

    check("txn_ended",   32'(ended),   32'd1);
    check("stall_cyc",   32'(stall_n), 32'(e_stall));
    check("req_cyc",     32'(req_n),   32'(e_req));
    check("err_pulses",  32'(err_n),   32'(e_err));
    check("rdv_pulses",  32'(val_n),   32'(e_val));
    check("bus_fields",  32'(bus_bad), 32'd0);
    if (e_val != 0) check("rdv_data", val_data, e_data);
    check("rdata_held",  mem_rdata,    e_data);
    last_rdata = e_data;
  endtask

  // A load that is reset while in WAIT_R. A later rvalid must be ignored.
  task automatic reset_in_wait_r();
    ex_mem_mem_read  = 1'b1;
    ex_mem_mem_write = 1'b0;
    ex_mem_alu_o     = 32'h40;
    dmem_gnt         = 1'b0;
    dmem_rvalid      = 1'b0;
    #3 check("rwr_idle_stall", 32'(mem_stall), 32'd1);
    @(posedge clk); #1;
    dmem_gnt = 1'b1;
    #3 check("rwr_req", 32'(dmem_req), 32'd1);
    @(posedge clk); #1;
    dmem_gnt        = 1'b0;
    ex_mem_mem_read = 1'b0;
    rst             = 1'b1;
    #3 check("rwr_wait_stall", 32'(mem_stall), 32'd1);
    @(posedge clk); #1;
    rst         = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hCAFE_F00D;
    #3;
    check("rwr_req_after", 32'(dmem_req),  32'd0);
    check("rwr_stall_after", 32'(mem_stall), 32'd0);
    @(posedge clk); #1;
    #3;
    check("rwr_no_rdv", 32'(mem_rdata_valid), 32'd0);
    check("rwr_rdata",  mem_rdata,            32'd0);
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    last_rdata  = '0;
  endtask

  initial begin
    rst                = 1'b1;
    ex_mem_mem_read    = 1'b0;
    ex_mem_mem_write   = 1'b0;
    ex_mem_alu_o       = '0;
    ex_mem_rs2_for_mem = '0;
    dmem_gnt           = 1'b0;
    dmem_rvalid        = 1'b0;
    dmem_rdata         = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", 32'(mem_stall),       32'd0);
    check("rst_req",   32'(dmem_req),        32'd0);
    check("rst_we",    32'(dmem_we),         32'd0);
    check("rst_addr",  dmem_addr,            32'd0);
    check("rst_wdata", dmem_wdata,           32'd0);
    check("rst_rdata", mem_rdata,            32'd0);
    check("rst_rdv",   32'(mem_rdata_valid), 32'd0);
    check("rst_err",   32'(mem_err),         32'd0);
    rst = 1'b0;

    // Directed cases.
    run_txn(1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, 0, 1, 32'h0, 1'b0);
    run_txn(1'b1, 1'b0, 32'h40,  32'h0, 3, 2, 32'h1234_5678, 1'b0);
    run_txn(1'b1, 1'b0, 32'h42,  32'h0, 0, 1, 32'h0, 1'b0);
    run_txn(1'b1, 1'b1, 32'h80,  32'h5, 0, 1, 32'h0, 1'b0);
    run_txn(1'b0, 1'b1, 32'h200, 32'hA5A5_5A5A, 99, 1, 32'h0, 1'b0);
    run_txn(1'b1, 1'b0, 32'h44,  32'h0, 0, 1, 32'h0BAD_F00D, 1'b1);
    run_txn(1'b1, 1'b0, 32'h48,  32'h0, 99, 1, 32'h1111_1111, 1'b0);
    run_txn(1'b1, 1'b0, 32'h4C,  32'h0, 1, T, 32'h2222_2222, 1'b0);
    run_txn(1'b1, 1'b0, 32'h50,  32'h0, 0, T + 2, 32'h3333_3333, 1'b0);
    reset_in_wait_r();

    // Randomized accesses.
    for (int i = 0; i < 40; i++) begin
      int          kind;
      logic [31:0] a;
      bit          rd, wr;
      kind = int'($urandom_range(0, 9));
      a    = $urandom & 32'hFFFF_FFFC;
      rd   = 1'b0;
      wr   = 1'b0;
      if (kind < 4) rd = 1'b1;
      else if (kind < 7) wr = 1'b1;
      else if (kind == 7) begin
        rd = 1'b1;
        a[1:0] = 2'($urandom_range(1, 3));
      end else if (kind == 8) begin
        rd = 1'b1;
        wr = 1'b1;
      end
      run_txn(rd, wr, a, $urandom, int'($urandom_range(0, T + 1)),
              int'($urandom_range(1, T + 1)), $urandom, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
